// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare direction predictor with an in-flight FIFO and history repair
package mips_core_pkg;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

module branch_predictor_gshare
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 10,
  parameter int HIST_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_fire,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output BranchOutcome          o_req_prediction,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  BranchOutcome          i_fb_prediction,
  input  BranchOutcome          i_fb_outcome,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts,
  output logic [2:0]            o_error
);
  localparam int GW = HIST_BITS > 0 ? HIST_BITS : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [1:0] pht [ENTRIES];
  logic [GW-1:0] ghr, ghr_nxt;
  logic [INDEX_BITS-1:0] q_idx [FIFO_DEPTH];
  logic [INDEX_BITS-1:0] q_pc [FIFO_DEPTH];
  logic [GW-1:0] q_ghr [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_nxt;
  logic [INDEX_BITS-1:0] req_slice, fb_slice, ghr_ext, idx, head_idx;
  logic [1:0] head_ctr, ctr_nxt;
  BranchOutcome pred;
  logic fire, empty, full, pop, mis, push, overflow, underflow, pc_err;
  logic unused_bits;
  assign unused_bits = ^{i_req_target, i_req_pc, i_fb_pc};
  assign req_slice = i_req_pc[INDEX_BITS+1:2];
  assign fb_slice = i_fb_pc[INDEX_BITS+1:2];
  assign ghr_ext = HIST_BITS == 0 ? '0 : INDEX_BITS'(ghr);
  assign idx = req_slice ^ ghr_ext;
  assign pred = BranchOutcome'(pht[idx][1]);
  assign o_req_prediction = pred;
  assign fire = i_req_valid & i_req_fire;
  assign empty = count == '0;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign pop = i_fb_valid & ~empty;
  assign underflow = i_fb_valid & empty;
  // a mispredict squashes any younger request firing in the same cycle
  assign mis = pop & (i_fb_prediction != i_fb_outcome);
  assign push = fire & ~mis & (~full | pop);
  assign overflow = fire & ~mis & full & ~pop;
  assign pc_err = pop & (fb_slice != q_pc[rd_ptr]);
  assign head_idx = q_idx[rd_ptr];
  assign head_ctr = pht[head_idx];
  always_comb begin
    ctr_nxt = i_fb_outcome == TAKEN ? (head_ctr == 2'b11 ? head_ctr : head_ctr + 2'd1)
                                    : (head_ctr == 2'b00 ? head_ctr : head_ctr - 2'd1);
    ghr_nxt = HIST_BITS == 0 ? '0
            : mis ? GW'({q_ghr[rd_ptr], i_fb_outcome})
            : fire ? GW'({ghr, pred}) : ghr;
    count_nxt = mis ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    else if (pop)
      pht[head_idx] <= ctr_nxt;
  always_ff @(posedge clk)
    if (push) begin
      q_idx[wr_ptr] <= idx;
      q_pc[wr_ptr] <= req_slice;
      q_ghr[wr_ptr] <= ghr;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ghr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      o_stat_branches <= '0;
      o_stat_mispredicts <= '0;
      o_error <= '0;
    end else begin
      ghr <= ghr_nxt;
      count <= count_nxt;
      wr_ptr <= mis ? '0 : wr_ptr + PW'(push);
      rd_ptr <= mis ? '0 : rd_ptr + PW'(pop);
      if (pop && o_stat_branches != '1) o_stat_branches <= o_stat_branches + 32'd1;
      if (mis && o_stat_mispredicts != '1) o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
      o_error <= o_error | {pc_err, underflow, overflow};
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed checks of a small gshare instance and a bimodal instance
module tb_branch_predictor_gshare;
  import mips_core_pkg::*;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_fire = 0, fb_valid = 0;
  logic [31:0] req_pc = 0, req_target = 0, fb_pc = 0;
  BranchOutcome fb_pred = NOT_TAKEN, fb_out = NOT_TAKEN;
  BranchOutcome pred_g, pred_b;
  logic [31:0] br_g, mp_g, br_b, mp_b;
  logic [2:0] err_g, err_b;
  int checks = 0, failures = 0;

  branch_predictor_gshare #(.ADDR_WIDTH(32), .INDEX_BITS(4), .HIST_BITS(3), .FIFO_DEPTH(4)) u_g (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_fire(req_fire), .i_req_pc(req_pc),
    .i_req_target(req_target), .o_req_prediction(pred_g), .i_fb_valid(fb_valid), .i_fb_pc(fb_pc),
    .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out), .o_stat_branches(br_g),
    .o_stat_mispredicts(mp_g), .o_error(err_g));

  branch_predictor_gshare #(.ADDR_WIDTH(32), .INDEX_BITS(4), .HIST_BITS(0), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_fire(req_fire), .i_req_pc(req_pc),
    .i_req_target(req_target), .o_req_prediction(pred_b), .i_fb_valid(fb_valid), .i_fb_pc(fb_pc),
    .i_fb_prediction(fb_pred), .i_fb_outcome(fb_out), .o_stat_branches(br_b),
    .o_stat_mispredicts(mp_b), .o_error(err_b));

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic f, input logic [31:0] pc, input logic fv,
                        input logic [31:0] fpc, input BranchOutcome fp, input BranchOutcome fo);
    req_valid = v; req_fire = f; req_pc = pc; req_target = pc + 32'h40;
    fb_valid = fv; fb_pc = fpc; fb_pred = fp; fb_out = fo;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset();
    set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN); tick();
    set_in(1, 1, 32'h404, 0, 0, NOT_TAKEN, NOT_TAKEN); tick();
    rst_n = 0;
    #1;
    checks++; if (u_g.count !== 3'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", u_g.count); end
    checks++; if (u_g.ghr !== 3'd0) begin failures++; $display("FAIL async_reset_ghr got=%0h exp=0", u_g.ghr); end
    checks++; if (br_g !== 32'd0 || mp_g !== 32'd0 || err_g !== 3'd0) begin failures++; $display("FAIL reset_stats got=%0h/%0h/%0h exp=0/0/0", br_g, mp_g, err_g); end
    rst_n = 1;
    set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN);
    checks++; if (pred_g !== NOT_TAKEN) begin failures++; $display("FAIL reset_pred got=%0d exp=0", pred_g); end
    tick();
    checks++; if (u_g.count !== 3'd1) begin failures++; $display("FAIL reset_fire_count got=%0d exp=1", u_g.count); end
    checks++; if (u_g.ghr !== 3'd0) begin failures++; $display("FAIL reset_fire_ghr got=%0h exp=0", u_g.ghr); end
    checks++; if (u_b.count !== 3'd1) begin failures++; $display("FAIL reset_fire_count_bim got=%0d exp=1", u_b.count); end
  endtask

  task automatic test_training;
    BranchOutcome exp_p [5] = '{NOT_TAKEN, TAKEN, TAKEN, TAKEN, TAKEN};
    BranchOutcome outs [5] = '{TAKEN, TAKEN, TAKEN, NOT_TAKEN, NOT_TAKEN};
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_in(1, 1, 32'h40C, 0, 0, NOT_TAKEN, NOT_TAKEN);
      checks++; if (pred_b !== exp_p[r]) begin failures++; $display("FAIL train_pred_%0d got=%0d exp=%0d", r, pred_b, exp_p[r]); end
      tick();
      set_in(0, 0, 0, 1, 32'h40C, exp_p[r], outs[r]);
      tick();
    end
    set_in(1, 0, 32'h40C, 0, 0, NOT_TAKEN, NOT_TAKEN);
    checks++; if (pred_b !== NOT_TAKEN) begin failures++; $display("FAIL train_final got=%0d exp=0", pred_b); end
    checks++; if (br_b !== 32'd5 || mp_b !== 32'd3) begin failures++; $display("FAIL train_stats got=%0d/%0d exp=5/3", br_b, mp_b); end
    checks++; if (err_b !== 3'd0) begin failures++; $display("FAIL train_err got=%0h exp=0", err_b); end
    tick();
  endtask

  task automatic test_mispredict;
    logic [31:0] pcs [3] = '{32'h400, 32'h404, 32'h408};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, pcs[i], 0, 0, NOT_TAKEN, NOT_TAKEN);
      checks++; if (pred_g !== NOT_TAKEN) begin failures++; $display("FAIL mis_pred_%0d got=%0d exp=0", i, pred_g); end
      tick();
    end
    checks++; if (u_g.count !== 3'd3 || u_g.ghr !== 3'd0) begin failures++; $display("FAIL mis_pre got=%0d/%0h exp=3/0", u_g.count, u_g.ghr); end
    set_in(1, 1, 32'h410, 1, 32'h400, NOT_TAKEN, TAKEN);
    tick();
    checks++; if (u_g.ghr !== 3'd1) begin failures++; $display("FAIL mis_ghr got=%0h exp=1", u_g.ghr); end
    checks++; if (u_g.count !== 3'd0) begin failures++; $display("FAIL mis_flush got=%0d exp=0", u_g.count); end
    checks++; if (mp_g !== 32'd1 || br_g !== 32'd1) begin failures++; $display("FAIL mis_stats got=%0d/%0d exp=1/1", mp_g, br_g); end
    checks++; if (err_g !== 3'd0) begin failures++; $display("FAIL mis_err got=%0h exp=0", err_g); end
    set_in(1, 0, 32'h404, 0, 0, NOT_TAKEN, NOT_TAKEN);
    checks++; if (pred_g !== TAKEN) begin failures++; $display("FAIL mis_trained got=%0d exp=1", pred_g); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 32'h404, 0, 0, NOT_TAKEN, NOT_TAKEN);
      checks++; if (pred_g !== TAKEN) begin failures++; $display("FAIL stall_pred_%0d got=%0d exp=1", i, pred_g); end
      @(posedge clk);
      #1;
    end
    tick();
    checks++; if (u_g.ghr !== 3'd1 || u_g.count !== 3'd0) begin failures++; $display("FAIL stall_state got=%0h/%0d exp=1/0", u_g.ghr, u_g.count); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN);
      tick();
      if (i == 3) begin
        checks++; if (u_g.count !== 3'd4 || err_g !== 3'd0) begin failures++; $display("FAIL ovf_fill got=%0d/%0h exp=4/0", u_g.count, err_g); end
      end
    end
    checks++; if (err_g !== 3'b001) begin failures++; $display("FAIL ovf_err got=%0h exp=1", err_g); end
    checks++; if (u_g.count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", u_g.count); end
    do_reset();
    checks++; if (err_g !== 3'd0) begin failures++; $display("FAIL ovf_reset got=%0h exp=0", err_g); end
    set_in(0, 0, 0, 1, 32'h400, TAKEN, NOT_TAKEN);
    tick();
    checks++; if (err_g !== 3'b010) begin failures++; $display("FAIL udf_err got=%0h exp=2", err_g); end
    checks++; if (br_g !== 32'd0 || mp_g !== 32'd0 || u_g.ghr !== 3'd0) begin failures++; $display("FAIL udf_state got=%0d/%0d/%0h exp=0/0/0", br_g, mp_g, u_g.ghr); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (u_g.pht[i] !== 2'b01) begin failures++; $display("FAIL udf_pht_%0d got=%0b exp=01", i, u_g.pht[i]); end
    end
    set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN); tick();
    set_in(0, 0, 0, 1, 32'h404, NOT_TAKEN, NOT_TAKEN); tick();
    checks++; if (err_g !== 3'b110) begin failures++; $display("FAIL pcmis_err got=%0h exp=6", err_g); end
    checks++; if (br_g !== 32'd1 || u_g.count !== 3'd0) begin failures++; $display("FAIL pcmis_state got=%0d/%0d exp=1/0", br_g, u_g.count); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN); tick();
    set_in(1, 1, 32'h400, 1, 32'h400, TAKEN, TAKEN);
    checks++; if (pred_g !== NOT_TAKEN) begin failures++; $display("FAIL nobypass_pred got=%0d exp=0", pred_g); end
    tick();
    checks++; if (u_g.count !== 3'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", u_g.count); end
    set_in(1, 1, 32'h400, 1, 32'h400, TAKEN, TAKEN);
    checks++; if (pred_g !== TAKEN) begin failures++; $display("FAIL b2b_pred got=%0d exp=1", pred_g); end
    tick();
    checks++; if (u_g.count !== 3'd1 || u_g.ghr !== 3'd1) begin failures++; $display("FAIL b2b_state got=%0d/%0h exp=1/1", u_g.count, u_g.ghr); end
    checks++; if (br_g !== 32'd2 || mp_g !== 32'd0) begin failures++; $display("FAIL b2b_stats got=%0d/%0d exp=2/0", br_g, mp_g); end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 32'h400, 0, 0, NOT_TAKEN, NOT_TAKEN); tick();
    end
    checks++; if (u_g.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", u_g.count); end
    set_in(1, 1, 32'h400, 1, 32'h400, TAKEN, TAKEN);
    checks++; if (pred_g !== TAKEN) begin failures++; $display("FAIL full_pred got=%0d exp=1", pred_g); end
    tick();
    checks++; if (u_g.count !== 3'd4 || err_g !== 3'd0 || u_g.ghr !== 3'd1) begin failures++; $display("FAIL full_popush got=%0d/%0h/%0h exp=4/0/1", u_g.count, err_g, u_g.ghr); end
    force u_g.o_stat_branches = 32'hFFFF_FFFE;
    #1;
    release u_g.o_stat_branches;
    set_in(0, 0, 0, 1, 32'h400, NOT_TAKEN, NOT_TAKEN); tick();
    checks++; if (br_g !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffffffff", br_g); end
    set_in(0, 0, 0, 1, 32'h400, NOT_TAKEN, NOT_TAKEN); tick();
    checks++; if (br_g !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffffffff", br_g); end
  endtask

  initial begin
    #1;
    test_reset();
    test_training();
    test_mispredict();
    test_stall();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised gshare direction predictor that succeeds the fixed 16-entry bimodal predictor behind `branch_controller`. It indexes a pattern history table (PHT) of 2-bit saturating counters by hashing PC bits with a speculative global history register (GHR). It keeps an in-order FIFO of in-flight predictions so that EX feedback updates the exact counter used at decode, and it repairs history on a mispredict. Setting `HIST_BITS=0` makes it behave as a parametrised bimodal predictor.

## Interface
- `INDEX_BITS`, default 10: PHT has 2^INDEX_BITS counters.
- `HIST_BITS`, default 8: GHR length. Range 0..INDEX_BITS; 0 selects bimodal mode.
- `FIFO_DEPTH`, default 4: maximum number of in-flight predictions. Must be a power of 2 and at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  1  decode holds a conditional branch.
- `i_req_fire`  in  1  decode advances this cycle. A request is consumed only when `i_req_valid & i_req_fire`.
- `i_req_pc`  in  `ADDR_WIDTH`  branch PC.
- `i_req_target`  in  `ADDR_WIDTH`  decoded target. Unused; kept for port compatibility.
- `o_req_prediction`  out  `mips_core_pkg::BranchOutcome`  predicted direction.
- `i_fb_valid`  in  1  EX resolved a branch this cycle.
- `i_fb_pc`  in  `ADDR_WIDTH`  resolved branch PC.
- `i_fb_prediction`  in  BranchOutcome  direction predicted for that branch.
- `i_fb_outcome`  in  BranchOutcome  actual direction.
- `o_stat_branches`  out  32  resolved-branch count, saturating.
- `o_stat_mispredicts`  out  32  mispredict count, saturating.
- `o_error`  out  3  sticky flags: bit0 overflow, bit1 underflow, bit2 PC mismatch.

## Operation
**Index**
- `idx = i_req_pc[INDEX_BITS+1:2] ^ {'0, ghr}`, with the GHR zero-extended to INDEX_BITS.
- When HIST_BITS=0 the index is the PC slice only.

**Prediction**
- `o_req_prediction` is TAKEN when `pht[idx][1]` is 1, otherwise NOT_TAKEN.
- It is combinational from `i_req_pc` and registered state.
- When `i_req_valid` is 0 the output is still driven but is don't-care.

**Request fire** (`i_req_valid & i_req_fire`)
- Push the entry {idx, GHR before the shift, `i_req_pc[INDEX_BITS+1:2]`} into the FIFO.
- Update the GHR to `{ghr[HIST_BITS-2:0], prediction}`. For HIST_BITS=1 the GHR simply becomes the prediction.

**Feedback** (`i_fb_valid`)
- Pop the FIFO head.
- Update `pht[head.idx]`: increment on TAKEN, saturating at 2'b11; decrement on NOT_TAKEN, saturating at 2'b00.
- Increment `o_stat_branches`.
- Mispredict is defined as `i_fb_prediction != i_fb_outcome`. On a mispredict:
  - Increment `o_stat_mispredicts`.
  - Set the GHR to `{head.ghr[HIST_BITS-2:0], i_fb_outcome}`.
  - Flush all remaining FIFO entries.
  - Ignore any request fire in the same cycle: that request is younger and is being squashed.
- If `i_fb_pc[INDEX_BITS+1:2] != head.pc`, set `o_error[2]`. The update still uses `head.idx`.
- Feedback with an empty FIFO sets `o_error[1]`. No PHT, GHR, or statistics change, except that `o_stat_branches` is not incremented either.

**Simultaneous correct feedback and request fire**
- Pop and push happen in the same cycle; the FIFO count is unchanged.
- The GHR shifts by the new prediction.

**FIFO full**
- A request fire while the count equals FIFO_DEPTH and no pop occurs that cycle:
  - The prediction is still returned and the GHR still shifts.
  - No entry is pushed and `o_error[0]` is set.

**Same-index read/write**
- A prediction reading the counter being updated in the same cycle sees the old value. There is no bypass.

**Statistics and flags**
- Statistics counters hold at 32'hFFFF_FFFF.
- `o_error` bits clear only on reset.

## Timing
**Reset** (asynchronous, takes effect immediately, including mid-operation)
- All PHT counters = 2'b01 (weakly not-taken).
- GHR = 0; FIFO empty (pointers and count 0).
- Statistics = 0; `o_error` = 0.
- `o_req_prediction` = NOT_TAKEN.

**Latency**
- Prediction: 0 cycles (same cycle as the request).
- PHT, GHR, and FIFO updates commit at the rising edge and are visible to predictions in the next cycle.

**Ordering rules**
- Feedback arrives in request order.
- Every fired request receives exactly one feedback unless it is flushed by a mispredict.
- A stalled decode holds `i_req_valid` high with `i_req_fire` low. Stalled cycles must not push entries or shift the GHR.

## Test plan
- **Reset:** release reset, fire pc=0x400 -> NOT_TAKEN. FIFO count becomes 1, GHR becomes 0.
- **Training (HIST_BITS=0):** fire and feed back pc=0x40C TAKEN three times, each as a mispredict-then-correct sequence -> next request for 0x40C predicts TAKEN. The counter saturates at 2'b11 after further TAKEN feedback.
- **Mispredict recovery:** fire 3 branches predicted NOT_TAKEN (GHR=000), then feed back the first with outcome TAKEN -> GHR = 0b1, FIFO empty, `o_stat_mispredicts` = 1. A request fired in the same cycle is not pushed.
- **Stall:** hold `i_req_valid`=1, `i_req_fire`=0 for 5 cycles -> FIFO count and GHR unchanged, prediction stable.
- **Overflow and underflow:** with FIFO_DEPTH=4, fire 5 requests with no feedback -> `o_error[0]`=1, count=4. After reset, feedback with an empty FIFO -> `o_error[1]`=1 and all PHT counters remain 2'b01.
- **Simultaneous events and saturation:** a correct feedback plus a request fire in the same cycle -> count unchanged. Preload `o_stat_branches` near 32'hFFFF_FFFF via a long run and force it -> holds at 32'hFFFF_FFFF.
